morse_accumulator: RTL and testbench
====================================

MORSE_ACCUMULATOR -- requirements
Module: morse_accumulator

Interface
REQ-001 Parameter MAX_SYMBOLS, 5: maximum symbols held per word; legal range 1..16.
REQ-002 Parameter MIN_PRESS_CYCLES, 2_500_000: presses of fewer cycles are treated as bounce and discarded.
REQ-003 Parameter DOT_MAX_CYCLES, 12_500_000: presses of up to this many cycles are dots; longer presses are lines.
REQ-004 Parameter GAP_CYCLES, 50_000_000: idle cycles before an auto-commit (used only under AUTO_COMMIT_EN).
REQ-005 Port clock, input, 1: the single clock; all logic on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port user_input, input, 1: raw asynchronous key, high = pressed.
REQ-008 Port next_input, input, 1: commit request, acted on at its rising edge.
REQ-009 Port write, output, 1: one-cycle commit strobe.
REQ-010 Port q, output, 2*MAX_SYMBOLS: accumulated code, newest symbol in bits [1:0].
REQ-011 Port count, output, $clog2(MAX_SYMBOLS+1): number of valid symbols in q.
REQ-012 Port overflow, output, 1: sticky flag, set when a symbol was dropped.
REQ-013 Port busy, output, 1: high while a press is in progress (states PRESS or WAIT_RELEASE).

Function
REQ-014 user_input and next_input SHALL each pass through a 2-flop synchroniser before any use.
REQ-015 The FSM SHALL have exactly four states: IDLE, PRESS, WAIT_RELEASE, COMMIT.
REQ-016 IDLE SHALL go to PRESS when the synchronised key is high, clearing the press counter.
REQ-017 PRESS SHALL increment the press counter every cycle, saturating at DOT_MAX_CYCLES+1.
REQ-018 On synchronised key low in PRESS, the FSM SHALL classify the press and return to IDLE.
REQ-019 A press shorter than MIN_PRESS_CYCLES SHALL be discarded; a press up to DOT_MAX_CYCLES SHALL append dot 2'b01; a longer press SHALL append line 2'b11.
REQ-020 Append SHALL be q <= {q[2*MAX_SYMBOLS-3:0], sym} and count+1, visible on the 3rd rising edge after user_input falls.
REQ-021 When count==MAX_SYMBOLS, a classified symbol SHALL be dropped, q and count SHALL hold, and overflow SHALL be set.
REQ-022 A next_input rising edge SHALL set a pending commit in any state; it is acted on only in IDLE.
REQ-023 IDLE with pending commit and count>0 SHALL go to COMMIT; with count==0 the pending commit SHALL be cleared and no write issued.
REQ-024 In COMMIT, write SHALL be 1 for exactly one cycle, with q, count and overflow still holding the committed word.
REQ-025 On the cycle after COMMIT, q, count, overflow and pending SHALL be 0 and the state SHALL be IDLE.
REQ-026 When release classification and a commit request coincide, the symbol SHALL be appended first and the commit issued one cycle later.
REQ-027 Holding next_input high SHALL produce only one commit.

Reset
REQ-028 On reset, q=0, count=0, overflow=0, write=0, pending=0 and the press counter SHALL be 0.
REQ-029 On reset with the synchronised key low, the FSM SHALL enter IDLE.
REQ-030 On reset with the synchronised key high, the FSM SHALL enter WAIT_RELEASE; that press yields no symbol.
REQ-031 WAIT_RELEASE SHALL go to IDLE on key low, without classification.
REQ-032 A reset during PRESS or COMMIT SHALL abort it; no write SHALL be emitted.

Configuration
REQ-033 With macro MORSE_ACCUMULATOR_AUTO_COMMIT_EN defined, GAP_CYCLES consecutive IDLE cycles with the key low and count>0 SHALL raise a commit identical to next_input.
REQ-034 Any press SHALL restart the gap counter.
REQ-035 Without the macro, no gap counter SHALL exist and commits SHALL come only from next_input.

Structure
REQ-036 Package morse_pkg SHALL hold the symbol constants MORSE_NONE=2'b00, MORSE_DOT=2'b01, MORSE_LINE=2'b11 and the FSM state encoding.
REQ-037 Sub-module morse_press_timer SHALL contain the key synchroniser, press counter and classifier, outputting a one-cycle sym_valid and a 2-bit sym.

Verification (bench parameters: MAX_SYMBOLS=5, MIN_PRESS_CYCLES=2, DOT_MAX_CYCLES=8, GAP_CYCLES=20)
REQ-038 Presses of 4, 12, then 4 cycles followed by a next_input pulse -> write=1 for one cycle with q=10'b00_00_01_11_01 and count=3, then q=0 and count=0.
REQ-039 A 1-cycle glitch press -> count stays 0 and no write occurs.
REQ-040 Six dot presses -> count=5, q=10'b0101010101, overflow=1, and overflow clears after the commit.
REQ-041 next_input while count=0, and next_input held high for 10 cycles after one symbol -> no write in the first case, exactly one write in the second.
REQ-042 reset asserted mid-press with the key held for 20 more cycles -> busy=1 until key release, after which count=0 and no symbol is added.
REQ-043 With MORSE_ACCUMULATOR_AUTO_COMMIT_EN defined, one line press then 20 idle cycles -> write with q=10'b11 and count=1; without the macro, no write occurs.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared symbol codes, FSM state encoding and press classifier for the Morse key accumulator.
package morse_pkg;

    localparam int unsigned SYM_W = 2;

    localparam logic [SYM_W-1:0] MORSE_NONE = 2'b00;
    localparam logic [SYM_W-1:0] MORSE_DOT  = 2'b01;
    localparam logic [SYM_W-1:0] MORSE_LINE = 2'b11;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS        = 2'd1,
        WAIT_RELEASE = 2'd2,
        COMMIT       = 2'd3
    } morse_state_e;

    // Maps a press duration (in cycles) onto the symbol it encodes.
    function automatic logic [SYM_W-1:0] classify_press(
        input int unsigned cycles,
        input int unsigned min_cycles,
        input int unsigned dot_max
    );
        if (cycles < min_cycles) begin
            return MORSE_NONE;
        end else if (cycles <= dot_max) begin
            return MORSE_DOT;
        end
        return MORSE_LINE;
    endfunction

endpackage

// File: rtl/morse_press_timer.sv
// Key synchroniser, saturating press-duration counter and dot/line classifier.
module morse_press_timer
    import morse_pkg::*;
#(
    parameter int unsigned MIN_PRESS_CYCLES = 2_500_000,
    parameter int unsigned DOT_MAX_CYCLES   = 12_500_000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             user_input,
    input  logic             start,
    input  logic             in_press,
    output logic             key_sync,
    output logic             sym_valid,
    output logic [SYM_W-1:0] sym
);

    localparam int unsigned CNT_MAX = DOT_MAX_CYCLES + 1;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic             key_meta;
    logic [CNT_W-1:0] press_cnt;
    logic [SYM_W-1:0] press_sym;

    // Synchroniser is deliberately not reset so a key held through reset stays visible.
    always_ff @(posedge clock) begin
        key_meta <= user_input;
        key_sync <= key_meta;
    end

    always_ff @(posedge clock) begin
        if (reset || start) begin
            press_cnt <= '0;
        end else if (in_press && (press_cnt != CNT_W'(CNT_MAX))) begin
            press_cnt <= press_cnt + CNT_W'(1);
        end
    end

    // The counter lags the key by one cycle, so the release cycle sees duration-1.
    always_comb begin
        press_sym = classify_press(32'(press_cnt) + 32'd1, MIN_PRESS_CYCLES, DOT_MAX_CYCLES);
        sym_valid = 1'b0;
        sym       = MORSE_NONE;
        if (in_press && !key_sync && (press_sym != MORSE_NONE)) begin
            sym_valid = 1'b1;
            sym       = press_sym;
        end
    end

endmodule

// File: rtl/morse_accumulator.sv
// Accumulates dot/line key presses into a word and strobes it out on commit.
// Optional MORSE_ACCUMULATOR_AUTO_COMMIT_EN adds an idle-gap auto-commit.
module morse_accumulator
    import morse_pkg::*;
#(
    parameter int unsigned MAX_SYMBOLS      = 5,
    parameter int unsigned MIN_PRESS_CYCLES = 2_500_000,
    parameter int unsigned DOT_MAX_CYCLES   = 12_500_000,
    parameter int unsigned GAP_CYCLES       = 50_000_000
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               user_input,
    input  logic                               next_input,
    output logic                               write,
    output logic [2*MAX_SYMBOLS-1:0]           q,
    output logic [$clog2(MAX_SYMBOLS+1)-1:0]   count,
    output logic                               overflow,
    output logic                               busy
);

    localparam int unsigned Q_W   = 2 * MAX_SYMBOLS;
    localparam int unsigned CNT_W = $clog2(MAX_SYMBOLS + 1);

    morse_state_e     state;
    logic             key_sync;
    logic             sym_valid;
    logic [SYM_W-1:0] sym;
    logic             next_meta;
    logic             next_sync;
    logic             next_prev;
    logic             next_rise_c;
    logic             pending;
    logic             gap_fire_c;
    logic             commit_go_c;
    logic             start_c;
    logic             in_press_c;

    assign commit_go_c = (state == IDLE) && pending && (count != '0);
    assign start_c     = (state == IDLE) && key_sync && !commit_go_c;
    assign in_press_c  = (state == PRESS);

    morse_press_timer #(
        .MIN_PRESS_CYCLES (MIN_PRESS_CYCLES),
        .DOT_MAX_CYCLES   (DOT_MAX_CYCLES)
    ) u_press_timer (
        .clock      (clock),
        .reset      (reset),
        .user_input (user_input),
        .start      (start_c),
        .in_press   (in_press_c),
        .key_sync   (key_sync),
        .sym_valid  (sym_valid),
        .sym        (sym)
    );

    // Commit request synchroniser plus one extra stage for rising-edge detection.
    always_ff @(posedge clock) begin
        next_meta <= next_input;
        next_sync <= next_meta;
        next_prev <= next_sync;
    end

    assign next_rise_c = next_sync && !next_prev;

`ifdef MORSE_ACCUMULATOR_AUTO_COMMIT_EN
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    logic [GAP_W-1:0] gap_cnt;
    logic             gap_arm_c;

    assign gap_arm_c  = (state == IDLE) && !key_sync && (count != '0) && !pending;
    assign gap_fire_c = gap_arm_c && (gap_cnt == GAP_W'(GAP_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || !gap_arm_c || gap_fire_c) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
        end
    end
`else
    logic unused_gap;

    assign unused_gap = (GAP_CYCLES != 0);
    assign gap_fire_c = 1'b0;
`endif

    // Word-building FSM; a pending commit waits in IDLE and beats a new press.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= key_sync ? WAIT_RELEASE : IDLE;
            busy     <= key_sync;
            write    <= 1'b0;
            q        <= '0;
            count    <= '0;
            overflow <= 1'b0;
            pending  <= 1'b0;
        end else begin
            write <= 1'b0;
            if (next_rise_c || gap_fire_c) begin
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (commit_go_c) begin
                        state <= COMMIT;
                        write <= 1'b1;
                    end else begin
                        if (pending) begin
                            pending <= 1'b0;
                        end
                        if (key_sync) begin
                            state <= PRESS;
                            busy  <= 1'b1;
                        end
                    end
                end
                PRESS: begin
                    if (!key_sync) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (sym_valid) begin
                            if (count == CNT_W'(MAX_SYMBOLS)) begin
                                overflow <= 1'b1;
                            end else begin
                                q     <= Q_W'({q, sym});
                                count <= count + CNT_W'(1);
                            end
                        end
                    end
                end
                WAIT_RELEASE: begin
                    if (!key_sync) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                COMMIT: begin
                    state    <= IDLE;
                    q        <= '0;
                    count    <= '0;
                    overflow <= 1'b0;
                    pending  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_accumulator.sv
// Directed bench for morse_accumulator with a per-cycle behavioural model and literal spot checks.
module tb_morse_accumulator;

    localparam int unsigned MAXS = 5;
    localparam int unsigned MINP = 2;
    localparam int unsigned DOTM = 8;
    localparam int unsigned GAP  = 20;

    logic       clock = 1'b0;
    logic       reset;
    logic       user_input;
    logic       next_input;
    logic       write;
    logic [9:0] q;
    logic [2:0] count;
    logic       overflow;
    logic       busy;

    morse_accumulator #(
        .MAX_SYMBOLS      (MAXS),
        .MIN_PRESS_CYCLES (MINP),
        .DOT_MAX_CYCLES   (DOTM),
        .GAP_CYCLES       (GAP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .user_input (user_input),
        .next_input (next_input),
        .write      (write),
        .q          (q),
        .count      (count),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int write_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: raw input sample histories ([0] = newest edge) and the expected outputs.
    logic [3:0] kh = '0;
    logic [3:0] nh = '0;
    int         run_len = 0;
    int         stash_len = 0;
    bit         run_void = 1'b0;
    bit         stash_void = 1'b1;
    logic [9:0] exp_q = '0;
    int         exp_count = 0;
    bit         exp_ovf = 1'b0;
    bit         exp_write = 1'b0;
    bit         exp_busy = 1'b0;
    bit         req_pending = 1'b0;
    bit         model_on = 1'b0;
    int         edges = 0;
`ifdef MORSE_ACCUMULATOR_AUTO_COMMIT_EN
    int         gap = 0;
`endif

    function automatic int sym_of(input int n);
        if (n < int'(MINP)) return 0;
        if (n <= int'(DOTM)) return 1;
        return 3;
    endfunction

    always @(posedge clock) begin : model
        bit pend_before;
        bit idle_before;
        bit commit_now;
        bit rise;
        int s;
`ifdef MORSE_ACCUMULATOR_AUTO_COMMIT_EN
        bit gap_arm;
`endif
        edges++;
        kh = {kh[2:0], user_input};
        nh = {nh[2:0], next_input};
        // Press length is the number of edges the raw key was sampled high.
        if (kh[0]) begin
            if (!kh[1]) begin
                run_len  = 1;
                run_void = reset;
            end else begin
                run_len++;
                run_void = run_void | reset;
            end
        end else if (kh[1]) begin
            stash_len  = run_len;
            stash_void = run_void | reset;
        end
        if (reset) begin
            exp_q       = '0;
            exp_count   = 0;
            exp_ovf     = 1'b0;
            exp_write   = 1'b0;
            req_pending = 1'b0;
            stash_void  = 1'b1;
            exp_busy    = kh[2];
`ifdef MORSE_ACCUMULATOR_AUTO_COMMIT_EN
            gap = 0;
`endif
            if (edges >= 3) model_on = 1'b1;
        end else if (model_on) begin
            pend_before = req_pending;
            idle_before = !kh[3] && !exp_write;
            rise        = nh[2] && !nh[3];
`ifdef MORSE_ACCUMULATOR_AUTO_COMMIT_EN
            gap_arm = idle_before && !kh[2] && (exp_count > 0) && !pend_before;
`endif
            if (exp_write) begin
                exp_q     = '0;
                exp_count = 0;
                exp_ovf   = 1'b0;
            end
            commit_now = 1'b0;
            if (rise) req_pending = 1'b1;
            if (pend_before && idle_before) begin
                req_pending = 1'b0;
                commit_now  = (exp_count > 0);
            end
            // The symbol lands three edges after the raw key is first sampled low.
            if (!kh[2] && kh[3] && !stash_void) begin
                s = sym_of(stash_len);
                if (s != 0) begin
                    if (exp_count == int'(MAXS)) begin
                        exp_ovf = 1'b1;
                    end else begin
                        exp_q = {exp_q[7:0], 2'(s)};
                        exp_count++;
                    end
                end
            end
`ifdef MORSE_ACCUMULATOR_AUTO_COMMIT_EN
            if (gap_arm) begin
                if (gap == int'(GAP) - 1) begin
                    req_pending = 1'b1;
                    gap = 0;
                end else begin
                    gap++;
                end
            end else begin
                gap = 0;
            end
`endif
            exp_write = commit_now;
            exp_busy  = kh[2];
        end
    end

    always @(negedge clock) begin
        if (model_on) begin
            check("q", int'(q), int'(exp_q));
            check("count", int'(count), exp_count);
            check("overflow", int'(overflow), int'(exp_ovf));
            check("write", int'(write), int'(exp_write));
            check("busy", int'(busy), int'(exp_busy));
        end
        if (write === 1'b1) write_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input int n);
        user_input = 1'b1;
        tick(n);
        user_input = 1'b0;
    endtask

    task automatic pulse_next(input int n);
        next_input = 1'b1;
        tick(n);
        next_input = 1'b0;
    endtask

    task automatic wait_write(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clock);
            if (write === 1'b1) seen = 1'b1;
        end
    endtask

    initial begin
        bit seen;
        int w0;
        reset      = 1'b1;
        user_input = 1'b0;
        next_input = 1'b0;
        tick(4);
        check("rst_q", int'(q), 0);
        check("rst_count", int'(count), 0);
        check("rst_write", int'(write), 0);
        check("rst_overflow", int'(overflow), 0);
        reset = 1'b0;
        tick(2);

        // dot, line, dot then commit
        press(4);  tick(6);
        press(12); tick(6);
        press(4);  tick(6);
        check("word3_count", int'(count), 3);
        pulse_next(1);
        wait_write(12, seen);
        check("word3_write_seen", int'(seen), 1);
        check("word3_commit_q", int'(q), 10'b00_00_01_11_01);
        check("word3_commit_count", int'(count), 3);
        tick(1);
        check("word3_clear_q", int'(q), 0);
        check("word3_clear_count", int'(count), 0);

        // glitch press is discarded
        w0 = write_cnt;
        press(1); tick(6);
        check("glitch_count", int'(count), 0);
        check("glitch_no_write", write_cnt - w0, 0);

        // overflow after six dots, cleared by commit
        repeat (6) begin
            press(3); tick(5);
        end
        check("ovf_count", int'(count), 5);
        check("ovf_q", int'(q), 10'h155);
        check("ovf_flag", int'(overflow), 1);
        pulse_next(1);
        wait_write(12, seen);
        check("ovf_write_seen", int'(seen), 1);
        tick(1);
        check("ovf_cleared", int'(overflow), 0);

        // commit with an empty word, then a held commit request
        w0 = write_cnt;
        pulse_next(1); tick(10);
        check("empty_no_write", write_cnt - w0, 0);
        press(10); tick(6);
        w0 = write_cnt;
        pulse_next(10); tick(6);
        check("held_one_write", write_cnt - w0, 1);
        check("held_cleared_count", int'(count), 0);

        // release classification coincides with a commit request
        press(5);
        pulse_next(2);
        wait_write(10, seen);
        check("coincide_write_seen", int'(seen), 1);
        check("coincide_q", int'(q), 10'b01);
        check("coincide_count", int'(count), 1);
        tick(4);

        // reset in the middle of a press
        user_input = 1'b1;
        tick(6);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(10);
        check("rst_press_busy_mid", int'(busy), 1);
        tick(9);
        check("rst_press_busy_end", int'(busy), 1);
        user_input = 1'b0;
        tick(6);
        check("rst_press_busy_off", int'(busy), 0);
        check("rst_press_count", int'(count), 0);

        // one line press followed by a long idle gap
        w0 = write_cnt;
        press(12);
`ifdef MORSE_ACCUMULATOR_AUTO_COMMIT_EN
        wait_write(40, seen);
        check("auto_write_seen", int'(seen), 1);
        check("auto_q", int'(q), 10'b11);
        check("auto_count", int'(count), 1);
        tick(4);
`else
        tick(40);
        check("gap_no_write", write_cnt - w0, 0);
        check("gap_count", int'(count), 1);
        check("gap_q", int'(q), 10'b11);
        pulse_next(1);
        tick(8);
        check("gap_manual_clear", int'(count), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
